// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width function and error-flag bit positions.
package fifo_pkg;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UDF = 1;
    localparam int unsigned ERR_W   = 2;

    // Ceiling log2 for n >= 2; gives the pointer width for n entries.
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned FD = 16,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [FD];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous show-ahead FIFO with level, threshold flags and sticky error flags.
// Depth need not be a power of two; pointers wrap explicitly.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned FD     = 16,
    parameter int unsigned DW     = 32,
    parameter int unsigned AF_LVL = FD - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic [DW-1:0]           fifo_in,
    input  logic                    fifo_wr_en,
    input  logic                    fifo_rd_en,
    input  logic                    err_clr,
    output logic [DW-1:0]           fifo_out,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    fifo_afull,
    output logic                    fifo_aempty,
    output logic [clogb2(FD):0]     fifo_level,
    output logic                    fifo_ovf,
    output logic                    fifo_udf
);

    localparam int unsigned PW  = clogb2(FD);
    localparam int unsigned FCW = PW + 1;

    generate
        if (!(FD >= 2 && AE_LVL < AF_LVL && AF_LVL <= FD)) begin : g_param_err
            $error("sync_fifo_flags: need FD >= 2 and AE_LVL < AF_LVL <= FD");
        end
    endgenerate

    logic [PW-1:0]    wp, rp, wp_nxt, rp_nxt;
    logic [FCW-1:0]   level_nxt;
    logic [ERR_W-1:0] err, err_nxt;
    logic             wr_ok, rd_ok, ovf_set, udf_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance decode uses only registered flags plus the request inputs.
    assign wr_ok   = clk_en & fifo_wr_en & (~fifo_full | fifo_rd_en);
    assign rd_ok   = clk_en & fifo_rd_en & ~fifo_empty;
    assign ovf_set = clk_en & fifo_wr_en & fifo_full & ~fifo_rd_en;
    assign udf_set = clk_en & fifo_rd_en & fifo_empty & ~fifo_wr_en;

    always_comb begin
        wp_nxt    = wp;
        rp_nxt    = rp;
        level_nxt = fifo_level;
        err_nxt   = err;
        if (clk_en) begin
            if (flush) begin
                wp_nxt    = '0;
                rp_nxt    = '0;
                level_nxt = '0;
                err_nxt   = '0;
            end else begin
                if (wr_ok) wp_nxt = ptr_inc(wp);
                if (rd_ok) rp_nxt = ptr_inc(rp);
                if (wr_ok && !rd_ok)      level_nxt = fifo_level + FCW'(1);
                else if (rd_ok && !wr_ok) level_nxt = fifo_level - FCW'(1);
                if (err_clr) err_nxt = '0;
                // A set condition in the same cycle overrides the clear.
                if (ovf_set) err_nxt[ERR_OVF] = 1'b1;
                if (udf_set) err_nxt[ERR_UDF] = 1'b1;
            end
        end
    end

    // Flags are registered alongside the level so they never see input paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            fifo_level  <= '0;
            err         <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            fifo_afull  <= (AF_LVL == 0);
            fifo_aempty <= 1'b1;
        end else begin
            wp          <= wp_nxt;
            rp          <= rp_nxt;
            fifo_level  <= level_nxt;
            err         <= err_nxt;
            fifo_full   <= (level_nxt == FCW'(FD));
            fifo_empty  <= (level_nxt == '0);
            fifo_afull  <= (level_nxt >= FCW'(AF_LVL));
            fifo_aempty <= (level_nxt <= FCW'(AE_LVL));
        end
    end

    assign fifo_ovf = err[ERR_OVF];
    assign fifo_udf = err[ERR_UDF];

    fifo_ram #(
        .DW (DW),
        .FD (FD),
        .AW (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~flush),
        .waddr (wp),
        .wdata (fifo_in),
        .raddr (rp),
        .rdata (fifo_out)
    );

endmodule
